// File: rtl/vec_exec_if.sv
// Handshake and data bundle between Decode, the vector execute pipeline and
// the WOM/Memory stage. The master side drives operands and out_ready, and the
// slave side (the pipeline) drives the results.
interface vec_exec_if #(
    parameter int LANES  = 4,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             in_op;
    logic                   in_acc_clr;
    logic [LANES*WIDTH-1:0] in_pix;
    logic [LANES*WIDTH-1:0] in_cte;
    logic [ADDR_W-1:0]      in_addr;
    logic                   in_wr_wom;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_res;
    logic [LANES-1:0]       out_sat;
    logic [ADDR_W-1:0]      out_addr;
    logic                   out_wr_wom;
    logic                   busy;

    modport master (
        output flush, in_valid, in_op, in_acc_clr, in_pix, in_cte, in_addr, in_wr_wom, out_ready,
        input  in_ready, out_valid, out_res, out_sat, out_addr, out_wr_wom, busy
    );

    modport slave (
        input  flush, in_valid, in_op, in_acc_clr, in_pix, in_cte, in_addr, in_wr_wom, out_ready,
        output in_ready, out_valid, out_res, out_sat, out_addr, out_wr_wom, busy
    );
endinterface

// File: rtl/vec_exec_pipe.sv
// Three-stage vector execute pipeline: S0 holds the operands, S1 holds the
// per-lane ALU/MAC result, and S2 drives the outputs. There is valid/ready
// back-pressure with bubble compression. flush clears every stage and the
// per-lane accumulators.
module vec_exec_pipe #(
    parameter int LANES  = 4,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter bit SAT    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    vec_exec_if.slave   bus
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    // S0: operand register
    logic                   v0;
    logic [1:0]             op0;
    logic                   acc_clr0;
    logic [LANES*WIDTH-1:0] pix0;
    logic [LANES*WIDTH-1:0] cte0;
    logic [ADDR_W-1:0]      addr0;
    logic                   wr0;
    // S1: execute register
    logic                   v1;
    logic [LANES*WIDTH-1:0] res1;
    logic [LANES-1:0]       sat1;
    logic [ADDR_W-1:0]      addr1;
    logic                   wr1;
    // S2: output register
    logic                   v2;
    logic [LANES*WIDTH-1:0] res2;
    logic [LANES-1:0]       sat2;
    logic [ADDR_W-1:0]      addr2;
    logic                   wr2;

    logic [WIDTH-1:0]       acc      [LANES];
    logic [WIDTH-1:0]       acc_next [LANES];

    logic [LANES*WIDTH-1:0] exe_res;
    logic [LANES-1:0]       exe_sat;
    logic [WIDTH-1:0]       opa;
    logic [WIDTH-1:0]       opb;
    logic [WIDTH:0]         sum;
    logic [WIDTH-1:0]       dif;
    logic [2*WIDTH-1:0]     prod;

    logic adv0, adv1, adv2, in_ready_i, accept, mac_xfer;

    // A stage moves when it is empty or its successor moves, so bubbles compress.
    assign adv2       = !v2 | bus.out_ready;
    assign adv1       = !v1 | adv2;
    assign adv0       = !v0 | adv1;
    assign in_ready_i = adv0 & !bus.flush;
    assign accept     = bus.in_valid & in_ready_i;
    assign mac_xfer   = adv1 & v0 & (op0 == 2'b11);

    assign bus.in_ready   = in_ready_i;
    assign bus.out_valid  = v2;
    assign bus.out_res    = res2;
    assign bus.out_sat    = sat2;
    assign bus.out_addr   = addr2;
    assign bus.out_wr_wom = v2 & wr2;
    assign bus.busy       = v0 | v1 | v2;

    // Per-lane ALU: unsigned add/sub/mul with optional clamp, and MAC into acc.
    always_comb begin
        exe_res = '0;
        exe_sat = '0;
        opa     = '0;
        opb     = '0;
        sum     = '0;
        dif     = '0;
        prod    = '0;
        for (int k = 0; k < LANES; k++) begin
            acc_next[k] = acc[k];
            opa  = pix0[k*WIDTH +: WIDTH];
            opb  = cte0[k*WIDTH +: WIDTH];
            sum  = {1'b0, opa} + {1'b0, opb};
            dif  = opa - opb;
            prod = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
            case (op0)
                OP_ADD: begin
                    exe_res[k*WIDTH +: WIDTH] = sum[WIDTH-1:0];
                    if (SAT && sum[WIDTH]) begin
                        exe_res[k*WIDTH +: WIDTH] = '1;
                        exe_sat[k] = 1'b1;
                    end
                end
                OP_SUB: begin
                    exe_res[k*WIDTH +: WIDTH] = dif;
                    if (SAT && (opa < opb)) begin
                        exe_res[k*WIDTH +: WIDTH] = '0;
                        exe_sat[k] = 1'b1;
                    end
                end
                OP_MUL: begin
                    exe_res[k*WIDTH +: WIDTH] = prod[WIDTH-1:0];
                    if (SAT && (|prod[2*WIDTH-1:WIDTH])) begin
                        exe_res[k*WIDTH +: WIDTH] = '1;
                        exe_sat[k] = 1'b1;
                    end
                end
                default: begin
                    // MAC always wraps. A new chain starts from zero when acc_clr is set.
                    acc_next[k] = (acc_clr0 ? {WIDTH{1'b0}} : acc[k]) + prod[WIDTH-1:0];
                    exe_res[k*WIDTH +: WIDTH] = acc_next[k];
                end
            endcase
        end
    end

    // S0 captures an accepted operand bundle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0       <= 1'b0;
            op0      <= '0;
            acc_clr0 <= 1'b0;
            pix0     <= '0;
            cte0     <= '0;
            addr0    <= '0;
            wr0      <= 1'b0;
        end else if (bus.flush) begin
            v0 <= 1'b0;
        end else if (adv0) begin
            v0 <= accept;
            if (accept) begin
                op0      <= bus.in_op;
                acc_clr0 <= bus.in_acc_clr;
                pix0     <= bus.in_pix;
                cte0     <= bus.in_cte;
                addr0    <= bus.in_addr;
                wr0      <= bus.in_wr_wom;
            end
        end
    end

    // S1 registers the execute result together with the bundle's control fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            res1  <= '0;
            sat1  <= '0;
            addr1 <= '0;
            wr1   <= 1'b0;
        end else if (bus.flush) begin
            v1 <= 1'b0;
        end else if (adv1) begin
            v1 <= v0;
            if (v0) begin
                res1  <= exe_res;
                sat1  <= exe_sat;
                addr1 <= addr0;
                wr1   <= wr0;
            end
        end
    end

    // The accumulator is read and written in the same S0->S1 transfer, so a MAC chain needs no forwarding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LANES; k++) acc[k] <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < LANES; k++) acc[k] <= '0;
        end else if (mac_xfer) begin
            for (int k = 0; k < LANES; k++) acc[k] <= acc_next[k];
        end
    end

    // S2 is the output register and holds steady while downstream stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2    <= 1'b0;
            res2  <= '0;
            sat2  <= '0;
            addr2 <= '0;
            wr2   <= 1'b0;
        end else if (bus.flush) begin
            v2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                res2  <= res1;
                sat2  <= sat1;
                addr2 <= addr1;
                wr2   <= wr1;
            end
        end
    end
endmodule
